// File: rtl/measure_freq_multi.sv
// Multi-channel frequency counter: per-channel edge counting over a shared gate
// window, with saturation, range alarms and min/max tracking.
module measure_freq_multi #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 28,
  parameter int unsigned C_REF_FREQ    = 50000000,
  parameter int unsigned C_GATE_CYCLES = 50000000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                    i_ref_clk,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_meas,
  input  logic                    i_en,
  input  logic                    i_clr_alarm,
  input  logic [NUM_CH*CNT_W-1:0] i_lo_thr,
  input  logic [NUM_CH*CNT_W-1:0] i_hi_thr,
  output logic [NUM_CH*CNT_W-1:0] o_freq,
  output logic                    o_valid,
  output logic [NUM_CH-1:0]       o_sat,
  output logic [NUM_CH-1:0]       o_alarm,
  output logic [NUM_CH*CNT_W-1:0] o_min,
  output logic [NUM_CH*CNT_W-1:0] o_max
);

  localparam int unsigned GATE_W = (C_GATE_CYCLES > 1) ? $clog2(C_GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(C_GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // C_REF_FREQ is informational only; it is referenced solely by this guard.
  if (C_REF_FREQ == 0 || C_GATE_CYCLES == 0 || SYNC_STAGES < 2) begin : g_param_check
    $error("measure_freq_multi: invalid parameter set");
  end

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0]       hist_q, hist_d;
  logic [NUM_CH-1:0]       edge_pulse;
  logic [GATE_W-1:0]       gate_q, gate_d;
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]       win_sat_q, win_sat_d;
  logic [NUM_CH*CNT_W-1:0] freq_q, freq_d;
  logic                    valid_q, valid_d;
  logic [NUM_CH-1:0]       sat_q, sat_d;
  logic [NUM_CH-1:0]       alarm_q, alarm_d;
  logic [NUM_CH-1:0]       armed_q, armed_d;
  logic [NUM_CH*CNT_W-1:0] min_q, min_d;
  logic [NUM_CH*CNT_W-1:0] max_q, max_d;
  logic                    terminal;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], i_meas};
    hist_d     = sync_q[SYNC_STAGES-1];
    edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_comb begin
    logic [CNT_W-1:0] cnt_k;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] lo_k;
    logic [CNT_W-1:0] hi_k;
    logic             at_max;
    logic             oor;

    cnt_k  = '0;
    result = '0;
    lo_k   = '0;
    hi_k   = '0;
    at_max = 1'b0;
    oor    = 1'b0;

    terminal = i_en && (gate_q == GATE_LAST);
    if (!i_en || terminal) begin
      gate_d = '0;
    end else begin
      gate_d = gate_q + GATE_W'(1);
    end
    valid_d = terminal;

    cnt_d     = cnt_q;
    win_sat_d = win_sat_q;
    freq_d    = freq_q;
    sat_d     = sat_q;
    alarm_d   = alarm_q;
    armed_d   = armed_q;
    min_d     = min_q;
    max_d     = max_q;

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cnt_k  = cnt_q[k*CNT_W +: CNT_W];
      at_max = (cnt_k == CNT_MAX);
      result = (edge_pulse[k] && !at_max) ? cnt_k + CNT_W'(1) : cnt_k;
      lo_k   = i_lo_thr[k*CNT_W +: CNT_W];
      hi_k   = i_hi_thr[k*CNT_W +: CNT_W];
      oor    = ((lo_k != '0) && (result < lo_k)) || (result > hi_k);

      if (i_clr_alarm) begin
        alarm_d[k] = 1'b0;
        armed_d[k] = 1'b0;
      end

      if (!i_en || terminal) begin
        cnt_d[k*CNT_W +: CNT_W] = '0;
        win_sat_d[k]            = 1'b0;
      end else begin
        cnt_d[k*CNT_W +: CNT_W] = result;
        win_sat_d[k]            = win_sat_q[k] | (edge_pulse[k] & at_max);
      end

      // Clear is applied first so a coincident result re-evaluates alarm and reloads min/max.
      if (terminal) begin
        freq_d[k*CNT_W +: CNT_W] = result;
        sat_d[k]                 = win_sat_q[k] | (edge_pulse[k] & at_max);
        alarm_d[k]               = alarm_d[k] | oor;
        if (!armed_d[k]) begin
          min_d[k*CNT_W +: CNT_W] = result;
          max_d[k*CNT_W +: CNT_W] = result;
        end else begin
          if (result < min_q[k*CNT_W +: CNT_W]) min_d[k*CNT_W +: CNT_W] = result;
          if (result > max_q[k*CNT_W +: CNT_W]) max_d[k*CNT_W +: CNT_W] = result;
        end
        armed_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      sync_q    <= '0;
      hist_q    <= '0;
      gate_q    <= '0;
      cnt_q     <= '0;
      win_sat_q <= '0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= '0;
      alarm_q   <= '0;
      armed_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      win_sat_q <= win_sat_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      alarm_q   <= alarm_d;
      armed_q   <= armed_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign o_freq  = freq_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;
  assign o_alarm = alarm_q;
  assign o_min   = min_q;
  assign o_max   = max_q;

endmodule

// File: tb/tb_measure_freq_multi.sv
// Directed bench: a wide (8-bit) and a narrow (4-bit, saturating) instance
// share stimulus; ch0 carries periodic test signals, ch1 is tied low.
module tb_measure_freq_multi;

  logic        clk = 1'b0;
  logic        rst, en, clr, m0;
  logic [1:0]  meas;
  logic [15:0] lo_thr, hi_thr;
  logic [15:0] freq, mn, mx;
  logic        valid;
  logic [1:0]  sat, alarm;
  logic [7:0]  n_lo, n_hi, n_freq, n_min, n_max;
  logic        n_valid;
  logic [1:0]  n_sat, n_alarm;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned gen_req = 0;

  assign meas = {1'b0, m0};

  initial forever #5 clk = ~clk;

  measure_freq_multi #(.NUM_CH(2), .CNT_W(8), .C_REF_FREQ(1000), .C_GATE_CYCLES(100), .SYNC_STAGES(2)) dut (
    .i_ref_clk(clk), .i_rst(rst), .i_meas(meas), .i_en(en), .i_clr_alarm(clr),
    .i_lo_thr(lo_thr), .i_hi_thr(hi_thr), .o_freq(freq), .o_valid(valid),
    .o_sat(sat), .o_alarm(alarm), .o_min(mn), .o_max(mx));

  measure_freq_multi #(.NUM_CH(2), .CNT_W(4), .C_REF_FREQ(1000), .C_GATE_CYCLES(100), .SYNC_STAGES(2)) dut_n (
    .i_ref_clk(clk), .i_rst(rst), .i_meas(meas), .i_en(en), .i_clr_alarm(clr),
    .i_lo_thr(n_lo), .i_hi_thr(n_hi), .o_freq(n_freq), .o_valid(n_valid),
    .o_sat(n_sat), .o_alarm(n_alarm), .o_min(n_min), .o_max(n_max));

  // Square-wave generator for ch0: period gen_p cycles, one rising edge per period.
  initial begin
    int unsigned gen_p;
    int unsigned gen_ph;
    gen_p  = 0;
    gen_ph = 0;
    m0     = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_req != gen_p) begin
        gen_p  = gen_req;
        gen_ph = 0;
      end
      if (gen_p == 0) begin
        m0 = 1'b0;
      end else begin
        m0     = (gen_ph < gen_p / 2);
        gen_ph = (gen_ph + 1 == gen_p) ? 0 : gen_ph + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] period;
    logic       clr;
    logic [7:0] lo0;
    logic [7:0] hi0;
    logic [7:0] freq0;
    logic [1:0] alarm;
    logic [7:0] min0;
    logic [7:0] max0;
    logic [3:0] nfreq0;
    logic [1:0] nsat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int unsigned cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid && cyc < 300);
  endtask

  task automatic expect_valid(input string name, input int unsigned exp_lat);
    int unsigned cyc;
    wait_valid(cyc);
    chk({name, "_lat"}, cyc, exp_lat);
    chk({name, "_nvalid"}, 32'(n_valid), 32'd1);
  endtask

  task automatic start_run(input logic [7:0] p, input logic c, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    en     = 1'b0;
    lo_thr = {8'h00, lo};
    hi_thr = {8'hFF, hi};
    if (c) begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
    gen_req = 32'(p);
    repeat (10) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic check_vec(input int unsigned i, input int unsigned w);
    string tag;
    tag = $sformatf("v%0d_w%0d", i, w);
    expect_valid(tag, 100);
    chk({tag, "_freq0"},  32'(freq[7:0]),   32'(vecs[i].freq0));
    chk({tag, "_freq1"},  32'(freq[15:8]),  32'd0);
    chk({tag, "_sat"},    32'(sat),         32'd0);
    chk({tag, "_alarm"},  32'(alarm),       32'(vecs[i].alarm));
    chk({tag, "_min0"},   32'(mn[7:0]),     32'(vecs[i].min0));
    chk({tag, "_max0"},   32'(mx[7:0]),     32'(vecs[i].max0));
    chk({tag, "_minmax1"}, 32'({mn[15:8], mx[15:8]}), 32'd0);
    chk({tag, "_nfreq0"}, 32'(n_freq[3:0]), 32'(vecs[i].nfreq0));
    chk({tag, "_nsat"},   32'(n_sat),       32'(vecs[i].nsat));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_freq"},  32'(freq),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_sat"},   32'(sat),   32'd0);
    chk({tag, "_alarm"}, 32'(alarm), 32'd0);
    chk({tag, "_min"},   32'(mn),    32'd0);
    chk({tag, "_max"},   32'(mx),    32'd0);
    chk({tag, "_n_all"}, 32'({n_freq, n_min, n_max, n_sat, n_alarm, n_valid}), 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    logic        bad_gap;
    logic        bad_hold;

    //                period clr lo      hi      freq0  alarm  min0   max0   nfreq nsat
    vecs[0] = '{8'd10, 1'b0, 8'd0,  8'hFF, 8'd10, 2'b00, 8'd10, 8'd10, 4'd10, 2'b00};
    vecs[1] = '{8'd5,  1'b0, 8'd0,  8'hFF, 8'd20, 2'b00, 8'd10, 8'd20, 4'd15, 2'b01};
    vecs[2] = '{8'd20, 1'b0, 8'd0,  8'hFF, 8'd5,  2'b00, 8'd5,  8'd20, 4'd5,  2'b00};
    vecs[3] = '{8'd4,  1'b0, 8'd0,  8'hFF, 8'd25, 2'b00, 8'd5,  8'd25, 4'd15, 2'b01};
    vecs[4] = '{8'd10, 1'b1, 8'd0,  8'hFF, 8'd10, 2'b00, 8'd10, 8'd10, 4'd10, 2'b00};
    vecs[5] = '{8'd10, 1'b0, 8'd0,  8'd9,  8'd10, 2'b01, 8'd10, 8'd10, 4'd10, 2'b00};
    vecs[6] = '{8'd10, 1'b1, 8'd10, 8'd10, 8'd10, 2'b00, 8'd10, 8'd10, 4'd10, 2'b00};
    vecs[7] = '{8'd10, 1'b1, 8'd11, 8'hFF, 8'd10, 2'b01, 8'd10, 8'd10, 4'd10, 2'b00};
    vecs[8] = '{8'd20, 1'b0, 8'd0,  8'hFF, 8'd5,  2'b01, 8'd5,  8'd10, 4'd5,  2'b00};

    rst    = 1'b1;
    en     = 1'b0;
    clr    = 1'b0;
    lo_thr = '0;
    hi_thr = '1;
    n_lo   = '0;
    n_hi   = '1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int unsigned i = 0; i < 9; i++) begin
      start_run(vecs[i].period, vecs[i].clr, vecs[i].lo0, vecs[i].hi0);
      check_vec(i, 0);
      check_vec(i, 1);
    end

    // Sticky alarm, clear mid-window, then clear coincident with a terminal cycle.
    start_run(8'd10, 1'b1, 8'd12, 8'hFF);
    expect_valid("alm_first", 100);
    chk("alm_first_alarm", 32'(alarm), 32'd1);
    chk("alm_first_min", 32'(mn[7:0]), 32'd10);
    repeat (20) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("alm_cleared", 32'(alarm), 32'd0);
    chk("alm_min_hold", 32'(mn[7:0]), 32'd10);
    chk("alm_max_hold", 32'(mx[7:0]), 32'd10);
    expect_valid("alm_again", 79);
    chk("alm_again_alarm", 32'(alarm), 32'd1);
    repeat (99) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("alm_coinc_valid", 32'(valid), 32'd1);
    chk("alm_coinc_alarm", 32'(alarm), 32'd1);
    chk("alm_coinc_minmax", 32'({mn[7:0], mx[7:0]}), 32'h0A0A);

    // Enable gap at gate cycle 50 for 30 cycles.
    repeat (50) @(negedge clk);
    en       = 1'b0;
    bad_gap  = 1'b0;
    bad_hold = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (valid) bad_gap = 1'b1;
      if (freq !== 16'h000A) bad_hold = 1'b1;
    end
    chk("gap_novalid", 32'(bad_gap), 32'd0);
    chk("gap_hold", 32'(bad_hold), 32'd0);
    en = 1'b1;
    expect_valid("gap_resume", 100);
    chk("gap_resume_freq", 32'(freq), 32'h000A);

    // Reset pulse at gate cycle 70.
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    wait_valid(cyc);
    chk("midrst_lat", cyc, 32'd100);
    chk("midrst_freq_in_range", 32'((freq[7:0] >= 8'd9) && (freq[7:0] <= 8'd11)), 32'd1);
    chk("midrst_freq1", 32'(freq[15:8]), 32'd0);
    chk("midrst_alarm", 32'(alarm), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
